// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU execute unit.
//   - 4-bit ALU control encodings produced by the decoder
//   - FSM state enum (MUL/DIV/DONE exist only when ALU_EXEC_MULDIV_EN is defined)
//   - funct3 / funct7 field constants for base integer and RV32M encodings
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_MULDIV = 4'd14,
        ALU_ILL    = 4'd15
    } alu_ctrl_e;

`ifdef ALU_EXEC_MULDIV_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_e;
`else
    typedef enum logic {
        ST_IDLE = 1'b0
    } state_e;
`endif

    // Base integer funct3
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // RV32M funct3
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [6:0] F7_MULDIV = 7'b0000001;
    localparam int         F7_ALT    = 5;   // funct7 bit selecting sub / sra

endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: iterative RV32M datapath (shift-add multiply, restoring divide).
// Operands are captured as magnitudes on start; one iteration per step cycle;
// after XLEN steps `result` holds the sign-corrected answer for the captured funct3.
// Ports:
//   clk     - clock
//   start   - capture SrcA/SrcB/funct3 and initialise the iteration registers
//   step    - perform one multiply and one divide iteration
//   funct3  - RV32M operation select
//   SrcA/B  - operands (XLEN)
//   result  - final value, valid once XLEN steps have been taken
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            start,
    input  logic            step,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    output logic [XLEN-1:0] result
);

    logic [2:0]        f3_q;
    logic [XLEN-1:0]   a_q, b_q;
    logic [2*XLEN-1:0] acc_q, mcand_q;
    logic [XLEN-1:0]   mplier_q;
    logic [XLEN-1:0]   rem_q, quot_q, dvsr_q;
    logic              neg_res_q, neg_rem_q;

    logic              signed_a, signed_b, a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     r_shift, diff;

    always_comb begin
        signed_a = funct3[2] ? (funct3 == F3_DIV || funct3 == F3_REM)
                             : (funct3 == F3_MULH || funct3 == F3_MULHSU);
        signed_b = funct3[2] ? signed_a : (funct3 == F3_MULH);
        a_neg    = signed_a && SrcA[XLEN-1];
        b_neg    = signed_b && SrcB[XLEN-1];
        a_mag    = a_neg ? -SrcA : SrcA;
        b_mag    = b_neg ? -SrcB : SrcB;
        // Restoring step: bring in the next dividend bit and try to subtract.
        // While rem < divisor, bit XLEN of diff is set exactly when the trial goes negative.
        r_shift  = {rem_q, quot_q[XLEN-1]};
        diff     = r_shift - {1'b0, dvsr_q};
    end

    always_ff @(posedge clk) begin
        if (start) begin
            f3_q      <= funct3;
            a_q       <= SrcA;
            b_q       <= SrcB;
            neg_res_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            acc_q     <= '0;
            mcand_q   <= {{XLEN{1'b0}}, a_mag};
            mplier_q  <= b_mag;
            rem_q     <= '0;
            quot_q    <= a_mag;
            dvsr_q    <= b_mag;
        end else if (step) begin
            if (mplier_q[0]) acc_q <= acc_q + mcand_q;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            if (!diff[XLEN]) begin
                rem_q  <= diff[XLEN-1:0];
                quot_q <= {quot_q[XLEN-2:0], 1'b1};
            end else begin
                rem_q  <= r_shift[XLEN-1:0];
                quot_q <= {quot_q[XLEN-2:0], 1'b0};
            end
        end
    end

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot_fix, rem_fix;
    logic              b_zero, ovf;

    always_comb begin
        prod     = neg_res_q ? -acc_q : acc_q;
        quot_fix = neg_res_q ? -quot_q : quot_q;
        rem_fix  = neg_rem_q ? -rem_q : rem_q;
        b_zero   = (b_q == '0);
        ovf      = (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1);
        result   = '0;
        case (f3_q)
            F3_MUL:                      result = prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: result = prod[2*XLEN-1:XLEN];
            F3_DIV:  result = b_zero ? '1  : (ovf ? a_q : quot_fix);
            F3_DIVU: result = b_zero ? '1  : quot_q;
            F3_REM:  result = b_zero ? a_q : (ovf ? '0 : rem_fix);
            F3_REMU: result = b_zero ? a_q : rem_q;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: RISC-V integer ALU execute stage with valid/ready handshakes.
// Single-cycle ops deliver a registered result one cycle after acceptance.
// With macro ALU_EXEC_MULDIV_EN defined, RV32M ops run on an iterative
// datapath (IDLE -> MUL/DIV for XLEN cycles -> DONE -> IDLE); without it
// those encodings report Illegal at latency 1.
// Ports:
//   clk, rst (async active-low)
//   in_valid/in_ready          - request handshake
//   ALUOp, op, funct3, funct7  - decode inputs
//   SrcA, SrcB                 - operands (XLEN)
//   out_valid/out_ready        - result handshake
//   Result, Zero, Illegal      - registered outputs, held while stalled
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      ALUOp,
    input  logic [6:0]      op,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] Result,
    output logic            Zero,
    output logic            Illegal
);

    localparam int SHW = $clog2(XLEN);

    state_e          state_q, state_d;
    alu_ctrl_e       ctrl;
    logic            accept;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] alu_res;
    logic            unused_op;

    assign unused_op = ^{op[6], op[4:0]};
    assign in_ready  = (state_q == ST_IDLE) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign shamt     = SrcB[SHW-1:0];
    assign Zero      = (Result == '0);

    always_comb begin
        ctrl = ALU_ILL;
        case (ALUOp)
            2'b00: ctrl = ALU_ADD;
            2'b01: ctrl = ALU_SUB;
            2'b10: begin
                if (op[5] && funct7 == F7_MULDIV) begin
`ifdef ALU_EXEC_MULDIV_EN
                    ctrl = ALU_MULDIV;
`else
                    ctrl = ALU_ILL;
`endif
                end else begin
                    case (funct3)
                        F3_ADD_SUB: ctrl = (op[5] && funct7[F7_ALT]) ? ALU_SUB : ALU_ADD;
                        F3_SLL:     ctrl = ALU_SLL;
                        F3_SLT:     ctrl = ALU_SLT;
                        F3_SLTU:    ctrl = ALU_SLTU;
                        F3_XOR:     ctrl = ALU_XOR;
                        F3_SRL_SRA: ctrl = funct7[F7_ALT] ? ALU_SRA : ALU_SRL;
                        F3_OR:      ctrl = ALU_OR;
                        default:    ctrl = ALU_AND;
                    endcase
                end
            end
            default: ctrl = ALU_ILL;
        endcase
    end

    always_comb begin
        alu_res = '0;
        case (ctrl)
            ALU_ADD:  alu_res = SrcA + SrcB;
            ALU_SUB:  alu_res = SrcA - SrcB;
            ALU_SLL:  alu_res = SrcA << shamt;
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (SrcA < SrcB)};
            ALU_XOR:  alu_res = SrcA ^ SrcB;
            ALU_SRL:  alu_res = SrcA >> shamt;
            ALU_SRA:  alu_res = $unsigned($signed(SrcA) >>> shamt);
            ALU_OR:   alu_res = SrcA | SrcB;
            ALU_AND:  alu_res = SrcA & SrcB;
            default:  alu_res = '0;
        endcase
    end

`ifdef ALU_EXEC_MULDIV_EN
    localparam int CNT_W = (SHW < 1) ? 1 : SHW;

    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0]  md_result;
    logic             md_start, md_step;

    assign md_start = accept && (ctrl == ALU_MULDIV);
    assign md_step  = (state_q == ST_MUL) || (state_q == ST_DIV);

    alu_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
        .clk    (clk),
        .start  (md_start),
        .step   (md_step),
        .funct3 (funct3),
        .SrcA   (SrcA),
        .SrcB   (SrcB),
        .result (md_result)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (md_start) state_d = funct3[2] ? ST_DIV : ST_MUL;
            ST_MUL,
            ST_DIV:  if (cnt_q == CNT_W'(XLEN-1)) state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          cnt_q <= '0;
        else if (md_start) cnt_q <= '0;
        else if (md_step)  cnt_q <= cnt_q + 1'b1;
    end
`else
    always_comb begin
        state_d = state_q;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            out_valid <= 1'b0;
            Result    <= '0;
            Illegal   <= 1'b0;
        end else begin
            state_q <= state_d;
            // A consumed result drops unless replaced in the same cycle below.
            if (out_valid && out_ready) out_valid <= 1'b0;
            if (accept && ctrl != ALU_MULDIV) begin
                out_valid <= 1'b1;
                Result    <= (ctrl == ALU_ILL) ? '0 : alu_res;
                Illegal   <= (ctrl == ALU_ILL);
            end
`ifdef ALU_EXEC_MULDIV_EN
            if (state_q == ST_DONE) begin
                out_valid <= 1'b1;
                Result    <= md_result;
                Illegal   <= 1'b0;
            end
`endif
        end
    end

endmodule
